// File: rtl/ladder_swap_ctrl.sv
// Conditional-swap initiator for the Montgomery ladder: scans the scalar
// MSB-first, drives cswap requests and sequences the ladder steps.
module ladder_swap_ctrl #(
    parameter int WID  = 256,
    parameter int NBIT = 255,
    parameter int IDXW = 8,
    parameter int TOUT = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [WID-1:0]  scalar,
    output logic            cs_en,
    output logic [WID-1:0]  cs_swap,
    output logic            cs_final,
    input  logic            cs_vld,
    output logic            step_req,
    input  logic            step_done,
    output logic [IDXW-1:0] bit_idx,
    output logic            busy,
    output logic            done,
    output logic            err
);

    localparam int TW = $clog2(TOUT + 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_SWAP_REQ,
        S_SWAP_WAIT,
        S_STEP_REQ,
        S_STEP_WAIT,
        S_FIN_REQ,
        S_FIN_WAIT,
        S_DONE,
        S_ERR
    } state_t;

    state_t          state_q, state_d;
    logic [WID-1:0]  k_q, k_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic [TW-1:0]   tmr_q, tmr_d;
    logic            swap_q, swap_d;
    logic            cs_en_q, cs_en_d;
    logic            cs_sw_q, cs_sw_d;
    logic            cs_final_q, cs_final_d;
    logic            step_req_q, step_req_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            err_q, err_d;

    logic            k_bit;
    logic            expired;

    assign k_bit   = |(k_q & (WID'(1) << idx_q));
    assign expired = (tmr_q == TW'(TOUT - 1));

    assign cs_en    = cs_en_q;
    assign cs_swap  = WID'(cs_sw_q);
    assign cs_final = cs_final_q;
    assign step_req = step_req_q;
    assign bit_idx  = idx_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            k_q        <= '0;
            idx_q      <= '0;
            tmr_q      <= '0;
            swap_q     <= 1'b0;
            cs_en_q    <= 1'b0;
            cs_sw_q    <= 1'b0;
            cs_final_q <= 1'b0;
            step_req_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            idx_q      <= idx_d;
            tmr_q      <= tmr_d;
            swap_q     <= swap_d;
            cs_en_q    <= cs_en_d;
            cs_sw_q    <= cs_sw_d;
            cs_final_q <= cs_final_d;
            step_req_q <= step_req_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        idx_d      = idx_q;
        tmr_d      = tmr_q;
        swap_d     = swap_q;
        cs_en_d    = 1'b0;
        cs_sw_d    = cs_sw_q;
        cs_final_d = cs_final_q;
        step_req_d = 1'b0;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = err_q;

        unique case (state_q)
            S_IDLE, S_ERR: begin
                if (start) begin
                    k_d     = scalar;
                    idx_d   = IDXW'(NBIT - 1);
                    swap_d  = 1'b0;
                    busy_d  = 1'b1;
                    err_d   = 1'b0;
                    state_d = S_SWAP_REQ;
                end
            end
            S_SWAP_REQ: begin
                cs_en_d = 1'b1;
                cs_sw_d = swap_q ^ k_bit;
                swap_d  = k_bit;
                tmr_d   = '0;
                state_d = S_SWAP_WAIT;
            end
            S_SWAP_WAIT: begin
                // a response on the expiry cycle still counts
                if (cs_vld) begin
                    state_d = S_STEP_REQ;
                end else if (expired) begin
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_ERR;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            S_STEP_REQ: begin
                step_req_d = 1'b1;
                state_d    = S_STEP_WAIT;
            end
            S_STEP_WAIT: begin
                if (step_done) begin
                    if (idx_q == '0) begin
                        state_d = S_FIN_REQ;
                    end else begin
                        idx_d   = idx_q - IDXW'(1);
                        state_d = S_SWAP_REQ;
                    end
                end
            end
            S_FIN_REQ: begin
                cs_en_d    = 1'b1;
                cs_sw_d    = swap_q;
                cs_final_d = 1'b1;
                tmr_d      = '0;
                state_d    = S_FIN_WAIT;
            end
            S_FIN_WAIT: begin
                if (cs_vld) begin
                    cs_final_d = 1'b0;
                    state_d    = S_DONE;
                end else if (expired) begin
                    cs_final_d = 1'b0;
                    err_d      = 1'b1;
                    busy_d     = 1'b0;
                    state_d    = S_ERR;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ladder_swap_ctrl.sv
// Bench for ladder_swap_ctrl: stub responder/ladder, protocol monitor and a
// bit-serial reference of the swap rule.
module tb_ladder_swap_ctrl;

    localparam int WID  = 8;
    localparam int NBIT = 4;
    localparam int IDXW = 8;
    localparam int TOUT = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic [WID-1:0]  scalar = '0;
    logic            cs_vld = 1'b0;
    logic            step_done = 1'b0;
    logic            cs_en;
    logic [WID-1:0]  cs_swap;
    logic            cs_final;
    logic            step_req;
    logic [IDXW-1:0] bit_idx;
    logic            busy;
    logic            done;
    logic            err;

    int total = 0;
    int bad = 0;

    int vld_dly = 3;
    int step_dly = 5;
    bit resp_on = 1'b1;
    bit spur_on = 1'b0;
    int vld_cnt = 0;
    int stp_cnt = 0;
    int spur_cnt = 0;

    int n_en = 0;
    int n_step = 0;
    int n_done = 0;
    int n_ovl = 0;
    int n_unstable = 0;
    int n_upper = 0;
    int en_sw[$];
    int en_fin[$];
    int en_idx[$];
    int step_idx[$];
    bit holding = 1'b0;
    logic [WID-1:0] held = '0;

    int exp_sw[NBIT+1];

    ladder_swap_ctrl #(
        .WID (WID),
        .NBIT(NBIT),
        .IDXW(IDXW),
        .TOUT(TOUT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .scalar   (scalar),
        .cs_en    (cs_en),
        .cs_swap  (cs_swap),
        .cs_final (cs_final),
        .cs_vld   (cs_vld),
        .step_req (step_req),
        .step_done(step_done),
        .bit_idx  (bit_idx),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    // monitor first, then stubs, so the monitor sees what the DUT consumed
    always @(negedge clk) begin
        if (rst) begin
            vld_cnt = 0;
            stp_cnt = 0;
            spur_cnt = 0;
            holding = 1'b0;
            cs_vld = 1'b0;
            step_done = 1'b0;
        end else begin
            if (cs_en) begin
                n_en++;
                en_sw.push_back(int'(cs_swap[0]));
                en_fin.push_back(int'(cs_final));
                en_idx.push_back(int'(bit_idx));
                if (cs_swap[WID-1:1] != '0) n_upper++;
                held = cs_swap;
                holding = 1'b1;
            end else if (holding) begin
                if (cs_swap !== held) n_unstable++;
                if (cs_vld) holding = 1'b0;
            end
            if (step_req) begin
                n_step++;
                step_idx.push_back(int'(bit_idx));
            end
            if (cs_en && step_req) n_ovl++;
            if (done) n_done++;

            cs_vld = 1'b0;
            step_done = 1'b0;
            if (vld_cnt != 0) begin
                vld_cnt--;
                if (vld_cnt == 0) cs_vld = 1'b1;
            end
            if (stp_cnt != 0) begin
                stp_cnt--;
                if (stp_cnt == 0) step_done = 1'b1;
            end
            if (spur_cnt != 0) begin
                spur_cnt--;
                if (spur_cnt == 0) cs_vld = 1'b1;
            end
            if (cs_en && resp_on) vld_cnt = vld_dly;
            if (step_req) begin
                stp_cnt = step_dly;
                if (spur_on) spur_cnt = 2;
            end
        end
    end

    // swap ^= k_t; cswap; swap = k_t -- then one trailing swap
    function automatic void build_model(input logic [WID-1:0] k);
        bit s;
        s = 1'b0;
        for (int t = NBIT - 1; t >= 0; t--) begin
            exp_sw[NBIT-1-t] = int'(s ^ k[t]);
            s = k[t];
        end
        exp_sw[NBIT] = int'(s);
    endfunction

    task automatic run_check(input string tag, input logic [WID-1:0] k,
                             input int mid);
        int e0, s0, d0, o0, u0, p0, b0, sb0, ei;
        bit fin;
        build_model(k);
        @(negedge clk); #1;
        e0 = n_en; s0 = n_step; d0 = n_done;
        o0 = n_ovl; u0 = n_unstable; p0 = n_upper;
        b0 = en_sw.size(); sb0 = step_idx.size();
        start = 1'b1;
        scalar = k;
        @(negedge clk); #1;
        start = 1'b0;
        fin = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk); #1;
            if (done || err) begin
                fin = 1'b1;
                break;
            end
            start = (i == mid);
            if (i == mid) scalar = ~k;
        end
        start = 1'b0;
        total++;
        if (!fin) begin
            bad++;
            $display("FAIL %s finish: got no done/err, want done", tag);
        end
        total++;
        if (err !== 1'b0) begin
            bad++;
            $display("FAIL %s err: got %b want 0", tag, err);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL %s busy_at_done: got %b want 0", tag, busy);
        end
        @(negedge clk); #1;
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL %s done_width: got %b want 0", tag, done);
        end
        total++;
        if (n_done - d0 !== 1) begin
            bad++;
            $display("FAIL %s done_count: got %0d want 1", tag, n_done - d0);
        end
        total++;
        if (n_en - e0 !== NBIT + 1) begin
            bad++;
            $display("FAIL %s cs_en_count: got %0d want %0d",
                     tag, n_en - e0, NBIT + 1);
        end
        total++;
        if (n_step - s0 !== NBIT) begin
            bad++;
            $display("FAIL %s step_count: got %0d want %0d",
                     tag, n_step - s0, NBIT);
        end
        for (int i = 0; i <= NBIT; i++) begin
            ei = (i < NBIT) ? NBIT - 1 - i : 0;
            total++;
            if (b0 + i >= en_sw.size()) begin
                bad++;
                $display("FAIL %s swap[%0d]: got none want %0d",
                         tag, i, exp_sw[i]);
            end else if (en_sw[b0+i] !== exp_sw[i] ||
                         en_fin[b0+i] !== int'(i == NBIT) ||
                         en_idx[b0+i] !== ei) begin
                bad++;
                $display("FAIL %s swap[%0d]: got sw=%0d fin=%0d idx=%0d want sw=%0d fin=%0d idx=%0d",
                         tag, i, en_sw[b0+i], en_fin[b0+i], en_idx[b0+i],
                         exp_sw[i], int'(i == NBIT), ei);
            end
        end
        for (int i = 0; i < NBIT; i++) begin
            total++;
            if (sb0 + i >= step_idx.size()) begin
                bad++;
                $display("FAIL %s step_idx[%0d]: got none want %0d",
                         tag, i, NBIT - 1 - i);
            end else if (step_idx[sb0+i] !== NBIT - 1 - i) begin
                bad++;
                $display("FAIL %s step_idx[%0d]: got %0d want %0d",
                         tag, i, step_idx[sb0+i], NBIT - 1 - i);
            end
        end
        total++;
        if (n_ovl != o0 || n_unstable != u0 || n_upper != p0) begin
            bad++;
            $display("FAIL %s protocol: got ovl=%0d unstable=%0d upper=%0d want 0 0 0",
                     tag, n_ovl - o0, n_unstable - u0, n_upper - p0);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #3;
        total++;
        if ({cs_en, cs_final, step_req, busy, done, err} !== 6'b0) begin
            bad++;
            $display("FAIL reset_flags: got %b want 000000",
                     {cs_en, cs_final, step_req, busy, done, err});
        end
        total++;
        if (cs_swap !== '0 || bit_idx !== '0) begin
            bad++;
            $display("FAIL reset_data: got swap=%h idx=%0d want 0 0",
                     cs_swap, bit_idx);
        end
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_swap_seq();
        vld_dly = 3;
        step_dly = 5;
        run_check("swap_seq", 8'h0B, -1);
    endtask

    task automatic test_zero();
        run_check("zero", 8'h00, -1);
    endtask

    task automatic test_vld_at_expiry();
        vld_dly = TOUT - 1;
        run_check("vld_expiry", 8'h06, -1);
        vld_dly = 3;
    endtask

    task automatic test_timeout();
        int d0, n;
        bit found;
        resp_on = 1'b0;
        d0 = n_done;
        @(negedge clk); #1;
        start = 1'b1;
        scalar = 8'h0B;
        @(negedge clk); #1;
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk); #1;
            if (cs_en) begin
                found = 1'b1;
                break;
            end
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL timeout cs_en: got none want pulse");
        end
        n = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk); #1;
            if (err) begin
                n = i;
                break;
            end
        end
        total++;
        if (n !== TOUT) begin
            bad++;
            $display("FAIL timeout latency: got %0d want %0d", n, TOUT);
        end
        repeat (5) @(negedge clk);
        #1;
        total++;
        if ({err, busy, cs_final} !== 3'b100) begin
            bad++;
            $display("FAIL timeout flags: got err/busy/fin=%b want 100",
                     {err, busy, cs_final});
        end
        total++;
        if (n_done != d0) begin
            bad++;
            $display("FAIL timeout done: got %0d want 0", n_done - d0);
        end
        resp_on = 1'b1;
        run_check("restart", 8'h0B, -1);
    endtask

    task automatic test_ignored();
        spur_on = 1'b1;
        run_check("ignored", 8'h0B, 12);
        spur_on = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit found;
        @(negedge clk); #1;
        start = 1'b1;
        scalar = 8'h0B;
        @(negedge clk); #1;
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk); #1;
            if (cs_en) begin
                found = 1'b1;
                break;
            end
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL rst_mid cs_en: got none want pulse");
        end
        @(negedge clk); #1;
        #2 rst = 1'b1;
        #1;
        total++;
        if ({cs_en, cs_final, step_req, busy, done, err} !== 6'b0) begin
            bad++;
            $display("FAIL rst_mid flags: got %b want 000000",
                     {cs_en, cs_final, step_req, busy, done, err});
        end
        total++;
        if (cs_swap !== '0 || bit_idx !== '0) begin
            bad++;
            $display("FAIL rst_mid data: got swap=%h idx=%0d want 0 0",
                     cs_swap, bit_idx);
        end
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        run_check("post_reset", 8'h0B, -1);
    endtask

    task automatic test_random();
        logic [WID-1:0] k;
        for (int r = 0; r < 8; r++) begin
            vld_dly = $urandom_range(TOUT - 1, 1);
            step_dly = $urandom_range(8, 1);
            k = WID'($urandom);
            run_check("random", k, -1);
        end
        vld_dly = 3;
        step_dly = 5;
    endtask

    initial begin
        test_reset();
        test_swap_seq();
        test_zero();
        test_vld_at_expiry();
        test_timeout();
        test_ignored();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ladder_swap_ctrl.md
Name: ladder_swap_ctrl

Overview:
- Initiator side of the conditional-swap interface used by the Montgomery scalar multiplier.
- Scans the scalar MSB-first and computes the per-bit swap decision (swap ^= k_t; cswap; swap = k_t).
- Issues single-cycle enable requests to the cswap responder, waits for its valid pulse, then hands each step to the ladder arithmetic via a req/done handshake.
- Issues the final post-loop swap and signals completion.

Parameters:
- WID, 256: data width of the swap word driven to the responder.
- NBIT, 255: number of scalar bits scanned, from index NBIT-1 down to 0.
- IDXW, 8: width of the bit index; must satisfy 2^IDXW >= NBIT.
- TOUT, 16: maximum cycles to wait for cs_vld before error.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high; one clock domain.
- start  in  1  begin scalar multiplication; sampled only in IDLE.
- scalar  in  WID  scalar k; latched on accepted start.
- cs_en  out  1  one-cycle request to the cswap responder.
- cs_swap  out  WID  swap word, value 0 or 1 zero-extended; registered and stable from cs_en until cs_vld.
- cs_final  out  1  high while the final swap is outstanding.
- cs_vld  in  1  responder completion pulse.
- step_req  out  1  one-cycle request to ladder arithmetic.
- step_done  in  1  ladder step completion pulse.
- bit_idx  out  IDXW  index of the current scalar bit.
- busy  out  1  high from accepted start until done or err.
- done  out  1  one-cycle completion pulse.
- err  out  1  responder timeout flag, sticky.

Behaviour:
- Reset (async): state IDLE. All outputs 0. Internal swap bit, index, timer and scalar register cleared.
- IDLE:
  - start=1: latch scalar, bit_idx<=NBIT-1, swap<=0, busy<=1, err<=0, go to SWAP_REQ.
  - start while not in IDLE: ignored.
- SWAP_REQ (1 cycle):
  - cs_en=1, cs_swap<=swap^k[bit_idx], swap<=k[bit_idx].
  - Clear timer, go to SWAP_WAIT.
- SWAP_WAIT:
  - cs_vld=1: go to STEP_REQ.
  - Otherwise timer increments; at timer==TOUT-1 without cs_vld, go to ERR.
  - cs_vld in the same cycle as expiry: cs_vld wins.
- STEP_REQ (1 cycle): step_req=1, go to STEP_WAIT.
- STEP_WAIT:
  - No timeout.
  - On step_done: if bit_idx==0 go to FIN_REQ; else bit_idx<=bit_idx-1 and go to SWAP_REQ.
- FIN_REQ (1 cycle): cs_en=1, cs_swap<=swap, cs_final<=1, clear timer, go to FIN_WAIT.
- FIN_WAIT:
  - cs_vld=1: cs_final<=0, go to DONE.
  - Timeout rule as in SWAP_WAIT.
- DONE (1 cycle): done=1, busy<=0, go to IDLE.
- ERR: err=1, busy=0, cs_final=0. Leave only on start (restarts normally, clears err) or rst.
- Ignored inputs:
  - cs_vld outside SWAP_WAIT/FIN_WAIT.
  - step_done outside STEP_WAIT.
- Totals per run: exactly NBIT step_req pulses and NBIT+1 cs_en pulses.
- cs_en and step_req are never high in the same cycle.
- No pipelining: at most one request outstanding.

Test Plan:
- Swap sequence (NBIT=4, WID=8, scalar=8'h0B, stub responder vld 3 cycles after cs_en, step_done 5 cycles after step_req) -> cs_swap sequence 1,1,1,0, final 1 with cs_final=1; bit_idx 3,2,1,0; one done pulse; busy low after done.
- Zero scalar (scalar=0) -> five cs_en, all cs_swap=0; four step_req; done asserted.
- Timeout (TOUT=16, responder never asserts cs_vld) -> err=1 exactly 16 cycles after cs_en; busy=0; no done; a new start clears err and the run completes.
- Ignored inputs -> start pulsed mid-run is ignored and the run completes with the original scalar; spurious cs_vld during STEP_WAIT causes no state change.
- Reset mid-run (async rst during SWAP_WAIT) -> all outputs 0 immediately without a clock edge; after release, start with scalar=8'h0B reproduces the first scenario exactly.
